// File: rtl/stopwatch_pkg.sv
// -----------------------------------------------------------------------------
// stopwatch_pkg
//   Shared types and default constants for the stopwatch control front end.
//   - sw_state_e     : mode FSM state encoding (IDLE, RUN, PAUSE, LAP)
//   - DEF_CLK_HZ     : default system clock frequency in Hz
//   - DEF_TICK_HZ    : default count-tick rate in Hz (centiseconds)
//   - DEF_DEB_CYCLES : default number of stable samples to accept a button level
//   - cnt_width()    : width of a counter that must hold 0..n-1, never below 1
// -----------------------------------------------------------------------------
package stopwatch_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2,
      LAP   = 2'd3
   } sw_state_e;

   localparam int DEF_CLK_HZ     = 50_000_000;
   localparam int DEF_TICK_HZ    = 100;
   localparam int DEF_DEB_CYCLES = 500_000;

   // $clog2(1) is 0, which would give a zero-width counter; clamp to 1 bit.
   function automatic int cnt_width(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/stopwatch_ctrl_debounce.sv
// -----------------------------------------------------------------------------
// sw_debounce
//   One raw push-button in, one press event out.
//   Raw input -> 2-FF synchronizer -> stability counter -> debounced level.
//   The level flips only after DEB_CYCLES consecutive synchronized samples
//   that differ from it; any sample equal to the level restarts the count.
//   press is a registered one-cycle pulse on the level's 0->1 change;
//   releases produce nothing.
//
// Ports
//   clk    in  system clock, rising edge
//   reset  in  asynchronous active-low reset
//   raw    in  raw active-high button, asynchronous, may bounce
//   press  out one-cycle press event
// -----------------------------------------------------------------------------
module sw_debounce
   import stopwatch_pkg::*;
#(
   parameter int DEB_CYCLES = DEF_DEB_CYCLES
) (
   input  logic clk,
   input  logic reset,
   input  logic raw,
   output logic press
);

   localparam int            CW       = cnt_width(DEB_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

   logic [1:0]    sync_q;
   logic [CW-1:0] cnt_q;
   logic          level_q;
   logic          sample;

   assign sample = sync_q[1];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync_q  <= '0;
         cnt_q   <= '0;
         level_q <= 1'b0;
         press   <= 1'b0;
      end else begin
         sync_q <= {sync_q[0], raw};
         press  <= 1'b0;
         if (sample == level_q) begin
            cnt_q <= '0;
         end else if (cnt_q == CNT_LAST) begin
            // This sample is the DEB_CYCLES-th differing one in a row.
            level_q <= sample;
            cnt_q   <= '0;
            press   <= sample;
         end else begin
            cnt_q <= cnt_q + 1'b1;
         end
      end
   end

endmodule

// File: rtl/stopwatch_ctrl.sv
// -----------------------------------------------------------------------------
// stopwatch_ctrl
//   Control front end of the real-time stopwatch: debounces the start/stop and
//   lap/reset buttons, runs the mode FSM and drives the counter chain.
//
// Parameters
//   CLK_HZ      system clock frequency in Hz
//   TICK_HZ     count-tick rate in Hz; DIV = CLK_HZ/TICK_HZ (>= 2)
//   DEB_CYCLES  consecutive stable samples to accept a button level (>= 1)
//
// Ports
//   clk        in  system clock, rising edge
//   reset      in  asynchronous active-low reset
//   btn_ss     in  raw start/stop button, active-high, may bounce
//   btn_lr     in  raw lap/reset button, active-high, may bounce
//   tick       out one-cycle pulse every DIV cycles while running
//   run        out level, high in RUN and LAP
//   run_tgl    out one-cycle strobe on every change of run (toggle-flop T)
//   clr        out one-cycle strobe that zeroes the counter chain
//   lap        out display freeze level, high only in LAP
//   dbg_state  out current FSM state, for observation only
//
// Build option
//   STOPWATCH_LAP_EN  defined: four-state FSM with LAP (display freeze).
//                     undefined: LAP is never entered, lr in RUN is ignored,
//                     lap is tied low.
// -----------------------------------------------------------------------------
module stopwatch_ctrl
   import stopwatch_pkg::*;
#(
   parameter int CLK_HZ     = DEF_CLK_HZ,
   parameter int TICK_HZ    = DEF_TICK_HZ,
   parameter int DEB_CYCLES = DEF_DEB_CYCLES
) (
   input  logic      clk,
   input  logic      reset,
   input  logic      btn_ss,
   input  logic      btn_lr,
   output logic      tick,
   output logic      run,
   output logic      run_tgl,
   output logic      clr,
   output logic      lap,
   output sw_state_e dbg_state
);

   localparam int            DIV      = CLK_HZ / TICK_HZ;
   localparam int            PW       = $clog2(DIV);
   localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);

   logic ss_press;
   logic lr_press;

   sw_debounce #(
      .DEB_CYCLES(DEB_CYCLES)
   ) u_deb_ss (
      .clk   (clk),
      .reset (reset),
      .raw   (btn_ss),
      .press (ss_press)
   );

   sw_debounce #(
      .DEB_CYCLES(DEB_CYCLES)
   ) u_deb_lr (
      .clk   (clk),
      .reset (reset),
      .raw   (btn_lr),
      .press (lr_press)
   );

   // ---------------------------------------------------------------------------
   // Mode FSM. ss is tested first in every state so a simultaneous lr press is
   // simply dropped.
   // ---------------------------------------------------------------------------
   sw_state_e state_q;
   sw_state_e state_d;
   logic      tgl_d;
   logic      clr_d;

   always_comb begin
      state_d = state_q;
      tgl_d   = 1'b0;
      clr_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (ss_press) begin
               state_d = RUN;
               tgl_d   = 1'b1;
            end else if (lr_press) begin
               clr_d = 1'b1;
            end
         end
         RUN: begin
            if (ss_press) begin
               state_d = PAUSE;
               tgl_d   = 1'b1;
            end
`ifdef STOPWATCH_LAP_EN
            else if (lr_press) begin
               state_d = LAP;
            end
`endif
         end
         PAUSE: begin
            if (ss_press) begin
               state_d = RUN;
               tgl_d   = 1'b1;
            end else if (lr_press) begin
               state_d = IDLE;
               clr_d   = 1'b1;
            end
         end
`ifdef STOPWATCH_LAP_EN
         LAP: begin
            if (ss_press) begin
               state_d = PAUSE;
               tgl_d   = 1'b1;
            end else if (lr_press) begin
               state_d = RUN;
            end
         end
`endif
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         run_tgl <= 1'b0;
         clr     <= 1'b0;
      end else begin
         state_q <= state_d;
         run_tgl <= tgl_d;
         clr     <= clr_d;
      end
   end

   assign run       = (state_q == RUN) || (state_q == LAP);
   assign dbg_state = state_q;

`ifdef STOPWATCH_LAP_EN
   assign lap = (state_q == LAP);
`else
   assign lap = 1'b0;
`endif

   // ---------------------------------------------------------------------------
   // Prescaler. Advances only while run is high and holds in PAUSE, so a resume
   // continues the interrupted interval. It is zeroed on the same edge that
   // raises clr; run is low in every state that can issue clr, so tick and clr
   // can never coincide.
   // ---------------------------------------------------------------------------
   logic [PW-1:0] pre_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pre_q <= '0;
         tick  <= 1'b0;
      end else begin
         tick <= 1'b0;
         if (clr_d) begin
            pre_q <= '0;
         end else if (run) begin
            if (pre_q == PRE_LAST) begin
               pre_q <= '0;
               tick  <= 1'b1;
            end else begin
               pre_q <= pre_q + 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
`timescale 1ns/1ps
module tb_stopwatch_ctrl;
   import stopwatch_pkg::*;

   localparam int CLK_HZ  = 100;
   localparam int TICK_HZ = 10;
   localparam int DEB     = 4;

   // clock / reset block
   logic clk    = 1'b0;
   logic reset  = 1'b1;
   logic btn_ss = 1'b0;
   logic btn_lr = 1'b0;

   logic      tick;
   logic      run;
   logic      run_tgl;
   logic      clr;
   logic      lap;
   sw_state_e dbg_state;

   always #5 clk = ~clk;

   stopwatch_ctrl #(
      .CLK_HZ     (CLK_HZ),
      .TICK_HZ    (TICK_HZ),
      .DEB_CYCLES (DEB)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .btn_ss    (btn_ss),
      .btn_lr    (btn_lr),
      .tick      (tick),
      .run       (run),
      .run_tgl   (run_tgl),
      .clr       (clr),
      .lap       (lap),
      .dbg_state (dbg_state)
   );

   // scoreboard
   int         n_cmp = 0;
   int         n_bad = 0;
   logic [5:0] exp_q[$];

   typedef struct packed {
      logic       ss;
      logic       lr;
      logic [5:0] want;   // {state, run, lap, run_tgl, clr}
   } vec_t;

   vec_t       vec[10];
   logic [5:0] prev_exp;
   int         tgl_count;
   int         tick_count;

   function automatic logic [5:0] pk(input sw_state_e s, input logic r,
                                     input logic l, input logic t, input logic c);
      return {s, r, l, t, c};
   endfunction

   function automatic logic [5:0] snap();
      return {dbg_state, run, lap, run_tgl, clr};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
      n_cmp++;
      if (act !== want) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, want);
      end
   endtask

   // driver tasks: inputs change 1 ns after a rising edge, outputs sampled there too
   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_reset();
      btn_ss = 1'b0;
      btn_lr = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      step(1);   // this edge is "edge 0" for latency counting
   endtask

   task automatic apply_row(input int i);
      btn_ss = vec[i].ss;
      btn_lr = vec[i].lr;
      exp_q.push_back(vec[i].want);
      step(6);
      chk($sformatf("row%0d_before_latency", i), snap(), prev_exp);
      step(1);
      chk($sformatf("row%0d_edge7", i), snap(), exp_q.pop_front());
      step(1);
      chk($sformatf("row%0d_strobe_width", i), {run_tgl, clr}, 2'b00);
      btn_ss = 1'b0;
      btn_lr = 1'b0;
      prev_exp = vec[i].want & 6'b111100;
      step(10);
   endtask

   // clr must never coincide with tick or run_tgl
   always @(negedge clk) begin
      if (reset === 1'b1 && clr === 1'b1)
         chk("clr_exclusive", {tick, run_tgl}, 2'b00);
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec[0] = '{1'b0, 1'b1, pk(IDLE,  1'b0, 1'b0, 1'b0, 1'b1)};
      vec[1] = '{1'b1, 1'b0, pk(RUN,   1'b1, 1'b0, 1'b1, 1'b0)};
`ifdef STOPWATCH_LAP_EN
      vec[2] = '{1'b0, 1'b1, pk(LAP,   1'b1, 1'b1, 1'b0, 1'b0)};
      vec[4] = '{1'b0, 1'b1, pk(LAP,   1'b1, 1'b1, 1'b0, 1'b0)};
`else
      vec[2] = '{1'b0, 1'b1, pk(RUN,   1'b1, 1'b0, 1'b0, 1'b0)};
      vec[4] = '{1'b0, 1'b1, pk(RUN,   1'b1, 1'b0, 1'b0, 1'b0)};
`endif
      vec[3] = '{1'b0, 1'b1, pk(RUN,   1'b1, 1'b0, 1'b0, 1'b0)};
      vec[5] = '{1'b1, 1'b0, pk(PAUSE, 1'b0, 1'b0, 1'b1, 1'b0)};
      vec[6] = '{1'b1, 1'b0, pk(RUN,   1'b1, 1'b0, 1'b1, 1'b0)};
      vec[7] = '{1'b1, 1'b1, pk(PAUSE, 1'b0, 1'b0, 1'b1, 1'b0)};
      vec[8] = '{1'b0, 1'b1, pk(IDLE,  1'b0, 1'b0, 1'b0, 1'b1)};
      vec[9] = '{1'b0, 1'b1, pk(IDLE,  1'b0, 1'b0, 1'b0, 1'b1)};

      // reset state
      #1 reset = 1'b0;
      #2;
      chk("reset_outputs", {tick, run, run_tgl, clr, lap}, 5'b0);
      chk("reset_state", dbg_state, IDLE);

      // clean press from reset, tick cadence, pause holding the prescaler
      do_reset();
      btn_ss = 1'b1;
      step(6);
      chk("clean_press_edge6_run", run, 1'b0);
      step(1);
      chk("clean_press_edge7_run", run, 1'b1);
      chk("clean_press_edge7_tgl", run_tgl, 1'b1);
      for (int k = 1; k <= 50; k++) begin
         exp_q.push_back({3'b000,
                          ((k < 15) || (k >= 31)),
                          ((k == 15) || (k == 31)),
                          ((k == 10) || (k == 36) || (k == 46))});
         step(1);
         chk($sformatf("run_pause_k%0d", k), {run, run_tgl, tick}, exp_q.pop_front());
         case (k)
            1:  btn_ss = 1'b0;
            8:  btn_ss = 1'b1;
            16: btn_ss = 1'b0;
            24: btn_ss = 1'b1;
            32: btn_ss = 1'b0;
            default: ;
         endcase
      end

      // bouncing button: one press, latency from the last rising transition
      do_reset();
      btn_ss = 1'b1;
      tgl_count = 0;
      for (int k = 1; k <= 30; k++) begin
         step(1);
         if (run_tgl === 1'b1) tgl_count++;
         if (k == 10) chk("bounce_edge10_run", run, 1'b0);
         if (k == 11) chk("bounce_edge11_run", run, 1'b1);
         case (k)
            1:  btn_ss = 1'b0;
            2:  btn_ss = 1'b1;
            3:  btn_ss = 1'b0;
            4:  btn_ss = 1'b1;
            20: btn_ss = 1'b0;
            default: ;
         endcase
      end
      chk("bounce_single_toggle", tgl_count, 1);

      // table-driven mode walk from IDLE
      do_reset();
      prev_exp = pk(IDLE, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 10; i++) apply_row(i);

      // after clr the prescaler restarts from zero: first tick DIV cycles later
      btn_ss = 1'b1;
      step(7);
      chk("restart_run", run, 1'b1);
      for (int k = 1; k <= 12; k++) begin
         exp_q.push_back({5'b0, (k == 10)});
         step(1);
         chk($sformatf("restart_tick_k%0d", k), tick, exp_q.pop_front());
         if (k == 1) btn_ss = 1'b0;
      end

      // lr in RUN: LAP with ticks continuing (or ignored without LAP)
      btn_lr = 1'b1;
      step(7);
`ifdef STOPWATCH_LAP_EN
      chk("lap_enter", snap(), pk(LAP, 1'b1, 1'b1, 1'b0, 1'b0));
`else
      chk("lap_enter", snap(), pk(RUN, 1'b1, 1'b0, 1'b0, 1'b0));
`endif
      tick_count = 0;
      for (int k = 1; k <= 20; k++) begin
         step(1);
         if (tick === 1'b1) tick_count++;
         if (k == 1) btn_lr = 1'b0;
      end
      chk("lap_ticks_20cyc", tick_count, 2);
      btn_lr = 1'b1;
      step(7);
      chk("lap_leave", snap(), pk(RUN, 1'b1, 1'b0, 1'b0, 1'b0));
      step(1);
      btn_lr = 1'b0;
      step(10);

      // reset mid-RUN with ss held through release
      btn_ss = 1'b1;
      step(3);
      #2 reset = 1'b0;
      #1;
      chk("midrun_reset_outputs", {tick, run, run_tgl, clr, lap}, 5'b0);
      chk("midrun_reset_state", dbg_state, IDLE);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      step(6);
      chk("held_press_edge6_run", run, 1'b0);
      step(1);
      chk("held_press_edge7", {run, run_tgl}, 2'b11);
      btn_ss = 1'b0;
      step(10);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
